// File: rtl/rr_arbiter_13_pkg.sv
// Shared constants, FSM state type and mask helpers for the 13-way
// round-robin arbiter.
package rr_arbiter_13_pkg;

  localparam int NUM_REQ = 13;
  localparam int IDX_W   = 4;
  localparam int HOLD_W  = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Bits strictly above p are kept, so p = 12 yields an all-zero mask.
  function automatic logic [NUM_REQ-1:0] upper_mask(input logic [IDX_W-1:0] p);
    logic [NUM_REQ-1:0] m;
    for (int i = 0; i < NUM_REQ; i++) begin
      m[i] = (IDX_W'(i) > p);
    end
    return m;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (IDX_W'(i) == idx);
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_13_prio_enc.sv
// Lowest-set-bit priority encoder over 13 request lines.
module priority_encoder_13bit
  import rr_arbiter_13_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = {IDX_W{1'b0}};
    valid_o = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_o = req_i[i] ? IDX_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/rr_arbiter_13.sv
// 13-requester round-robin arbiter with done/abort release, a hold-time
// limit that force-releases a grant, and one dead cycle after each release.
module rr_arbiter_13
  import rr_arbiter_13_pkg::*;
#(
  parameter int HOLD_MAX = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o,
  output logic               timeout_o
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rel_q, rel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] masked_s;
  logic [IDX_W-1:0]   m_idx_s, u_idx_s, win_idx_s;
  logic               m_vld_s, u_vld_s;
  logic               abort_s, hold_hit_s, release_s;

  assign masked_s = req_i & upper_mask(ptr_q);

  priority_encoder_13bit u_enc_masked (
    .req_i   (masked_s),
    .idx_o   (m_idx_s),
    .valid_o (m_vld_s)
  );

  priority_encoder_13bit u_enc_unmasked (
    .req_i   (req_i),
    .idx_o   (u_idx_s),
    .valid_o (u_vld_s)
  );

  assign win_idx_s  = m_vld_s ? m_idx_s : u_idx_s;
  assign abort_s    = ~(|(req_i & grant_q));
  assign hold_hit_s = (hold_q == HOLD_LAST);
  assign release_s  = done_i | abort_s | hold_hit_s;

  // Next-state and next-output logic; rel_q blocks arbitration for the
  // cycle right after a release, giving the two-cycle gap between grants.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    rel_d     = 1'b0;
    grant_d   = grant_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rel_q && u_vld_s) begin
          state_d = ST_GRANT;
          grant_d = onehot(win_idx_s);
          idx_d   = win_idx_s;
          valid_d = 1'b1;
          hold_d  = {HOLD_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_d   = ST_IDLE;
          ptr_d     = idx_q;
          grant_d   = {NUM_REQ{1'b0}};
          idx_d     = {IDX_W{1'b0}};
          valid_d   = 1'b0;
          hold_d    = {HOLD_W{1'b0}};
          rel_d     = 1'b1;
          timeout_d = hold_hit_s & ~done_i & ~abort_s;
        end else begin
          hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_REQ{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        valid_d = 1'b0;
        hold_d  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 4'd12;
      hold_q    <= {HOLD_W{1'b0}};
      rel_q     <= 1'b0;
      grant_q   <= {NUM_REQ{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      rel_q     <= rel_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = valid_q;
  assign timeout_o     = timeout_q;

endmodule

// File: doc/rr_arbiter_13.md
RR_ARBITER_13 -- requirements
Module: rr_arbiter_13

Interface
REQ-001 Parameter HOLD_MAX, default 255, SHALL set the maximum cycles a grant may be held before forced release (range 1..255).
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req_i  input  13  SHALL carry the per-requester request levels; bit k is requester k.
REQ-005 done_i  input  1  SHALL carry the single-cycle release pulse from the current grant holder.
REQ-006 grant_o  output  13  SHALL carry the registered one-hot grant vector.
REQ-007 grant_idx_o  output  4  SHALL carry the binary index of the granted requester (0..12).
REQ-008 grant_valid_o  output  1  SHALL be high exactly when grant_o is nonzero.
REQ-009 timeout_o  output  1  SHALL pulse for one cycle when a grant is force-released by the hold limit.

Function
REQ-010 FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req_i nonzero, the block SHALL select a winner and enter GRANT; grant_o, grant_idx_o and grant_valid_o SHALL be valid from the next cycle (1-cycle latency).
REQ-012 In IDLE with req_i zero, all outputs SHALL remain zero and the state SHALL remain IDLE.
REQ-013 Winner selection: masked = req_i with bits 0..ptr cleared; if masked is nonzero, winner = lowest set bit of masked, else winner = lowest set bit of req_i.
REQ-014 ptr (4 bits, 0..12) SHALL hold the index of the last released grant; with ptr = 12 the mask SHALL be all zero, so selection wraps to the lowest set bit of req_i.
REQ-015 In GRANT, outputs SHALL hold constant until a release event.
REQ-016 Release events: done_i high; granted bit of req_i low (abort); or hold counter equal to HOLD_MAX-1.
REQ-017 On any release, ptr SHALL load grant_idx_o, outputs SHALL clear the next cycle, and the state SHALL return to IDLE.
REQ-018 With back-to-back requests, two idle cycles SHALL separate one grant's last cycle from the next grant's first cycle (one release cycle plus one IDLE arbitration cycle).
REQ-019 Hold counter (8 bits) SHALL clear on entry to GRANT and increment each GRANT cycle without release; it SHALL never wrap.
REQ-020 timeout_o SHALL assert only when the hold limit is the sole release cause; done_i or abort in the same cycle SHALL suppress timeout_o.
REQ-021 done_i SHALL be ignored in IDLE.
REQ-022 req_i changes on non-granted bits during GRANT SHALL have no effect until the next IDLE arbitration.

Reset
REQ-023 While rst_i is high at a clock edge: state = IDLE, ptr = 12, hold counter = 0, and grant_o, grant_idx_o, grant_valid_o and timeout_o = 0.
REQ-024 Reset asserted mid-grant SHALL drop the grant the next cycle without a timeout_o pulse; after reset, the first arbitration SHALL favour requester 0.

Structure
REQ-025 The shared package SHALL hold: NUM_REQ = 13, IDX_W = 4, HOLD_W = 8, and the FSM state enum.
REQ-026 Lowest-set-bit selection SHALL use two instances of priority_encoder_13bit (masked and unmasked), with selection by the masked instance's valid_o.
REQ-027 The RTL SHALL be one module of 120-400 lines plus the encoder instances.

Verification
REQ-028 Reset, then req_i = 13'h1FFF held, done_i pulsed in each GRANT -> grant_idx_o sequence 0,1,2,...,12,0.
REQ-029 ptr = 4 (last grant was 4), req_i = 13'b0000000010001 -> grant_idx_o = 0 via wrap; then with only bit 4 requesting -> grant_idx_o = 4.
REQ-030 HOLD_MAX = 8, single request bit 7, no done_i -> grant held exactly 8 cycles, timeout_o pulses once, regrant to 7 two cycles later.
REQ-031 Granted requester 3 drops req_i while holding -> grant clears next cycle, no timeout_o, ptr = 3.
REQ-032 done_i and hold limit in the same cycle -> release with timeout_o = 0.
REQ-033 rst_i asserted mid-grant -> all outputs zero next cycle; with req_i = 13'h1FFF, the next grant is index 0.
